// File: rtl/holo_mem_sequencer.sv
// Purpose: arbitrates fetch and load/store requests onto an 8-bit synchronous memory, little-endian byte beats.
// Latency: ack in C(N+2) for reads, C(N+1) for writes, C1 for rejects (N = 1/2/4 beats).
// Backpressure: requesters hold req until the ack pulse; at most one transfer is in flight at a time.
//
// Ports:
//   clk, rst                          core clock, asynchronous active-high reset
//   ifetch_req/addr -> ack/data/err   instruction-fetch port (always 32-bit words)
//   data_req/we/f3/addr/wdata         load/store port (LB/LH/LW/LBU/LHU/SB/SH/SW)
//     -> data_ack/rdata/err
//   mem_addr/re/we/wdata, mem_rdata   byte memory bus; read data arrives one cycle after mem_re
//
// Build option: define MISALIGN_TRAP_EN to reject misaligned halves/words (and fetches)
// with ack+err instead of performing them bytewise.
module holo_mem_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifetch_req,
    input  logic [ADDR_W-1:0] ifetch_addr,
    output logic              ifetch_ack,
    output logic [31:0]       ifetch_data,
    output logic              ifetch_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [2:0]        data_f3,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_ack,
    output logic [31:0]       data_rdata,
    output logic              data_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDCAP,
        S_WR,
        S_ERR,
        S_ACK
    } state_t;

    state_t      state;
    logic        last_data;   // 1 when the data port won the most recent tie
    logic        own_fetch;   // current transfer belongs to the fetch port
    logic [2:0]  f3_q;
    logic [1:0]  beat_idx;
    logic [1:0]  last_beat;
    logic [1:0]  cap_idx;
    logic [31:0] wsh;         // remaining store bytes, next one in [7:0]
    logic [31:0] rbuf;        // captured load bytes
    logic        re_d;        // mem_rdata carries a requested byte this cycle

    logic        gnt_fetch;
    logic        gnt_data;
    logic [1:0]  d_last;
    logic        d_illegal;
    logic        d_mis;
    logic        f_mis;
    logic [31:0] word;
    logic [31:0] ext;

    // Round-robin only advances on a genuine tie; an uncontested grant does not
    // move the pointer, so consecutive ties alternate strictly.
    always_comb begin
        gnt_fetch = ifetch_req && (!data_req || last_data);
        gnt_data  = data_req && !gnt_fetch;
    end

    always_comb begin
        case (data_f3[1:0])
            2'b00:   d_last = 2'd0;
            2'b01:   d_last = 2'd1;
            default: d_last = 2'd3;
        endcase
        // Loads accept 000/001/010/100/101; stores accept 000/001/010.
        d_illegal = data_we ? (data_f3[2] || data_f3[1:0] == 2'b11)
                            : (data_f3[1:0] == 2'b11 || data_f3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
        d_mis = (data_f3[1:0] == 2'b01 && data_addr[0]) ||
                (data_f3[1:0] == 2'b10 && data_addr[1:0] != 2'b00);
        f_mis = ifetch_addr[1:0] != 2'b00;
`else
        d_mis = 1'b0;
        f_mis = 1'b0;
`endif
    end

    // The final byte arrives in the RDCAP cycle; merge it combinationally so the
    // result can be registered straight into the ack cycle.
    always_comb begin
        word = rbuf;
        word[{cap_idx, 3'b000} +: 8] = mem_rdata;
        case (f3_q)
            3'b000:  ext = {{24{word[7]}}, word[7:0]};
            3'b001:  ext = {{16{word[15]}}, word[15:0]};
            3'b100:  ext = {24'h000000, word[7:0]};
            3'b101:  ext = {16'h0000, word[15:0]};
            default: ext = word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_data   <= 1'b1;
            own_fetch   <= 1'b0;
            f3_q        <= 3'b000;
            beat_idx    <= 2'd0;
            last_beat   <= 2'd0;
            cap_idx     <= 2'd0;
            wsh         <= 32'h0;
            rbuf        <= 32'h0;
            re_d        <= 1'b0;
            ifetch_ack  <= 1'b0;
            ifetch_data <= 32'h0;
            ifetch_err  <= 1'b0;
            data_ack    <= 1'b0;
            data_rdata  <= 32'h0;
            data_err    <= 1'b0;
            mem_addr    <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'h00;
        end else begin
            ifetch_ack <= 1'b0;
            ifetch_err <= 1'b0;
            data_ack   <= 1'b0;
            data_err   <= 1'b0;
            re_d       <= mem_re;
            if (re_d) begin
                rbuf[{cap_idx, 3'b000} +: 8] <= mem_rdata;
                cap_idx <= cap_idx + 2'd1;
            end
            case (state)
                S_IDLE: begin
                    beat_idx <= 2'd0;
                    cap_idx  <= 2'd0;
                    if (ifetch_req && data_req)
                        last_data <= gnt_data;
                    own_fetch <= gnt_fetch;
                    if (gnt_fetch) begin
                        f3_q      <= 3'b010;
                        last_beat <= 2'd3;
                        if (f_mis) begin
                            state      <= S_ERR;
                            ifetch_ack <= 1'b1;
                            ifetch_err <= 1'b1;
                        end else begin
                            state    <= S_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= ifetch_addr;
                        end
                    end else if (gnt_data) begin
                        f3_q      <= data_f3;
                        last_beat <= d_last;
                        if (d_illegal || d_mis) begin
                            state    <= S_ERR;
                            data_ack <= 1'b1;
                            data_err <= 1'b1;
                        end else if (data_we) begin
                            state     <= S_WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata[7:0];
                            wsh       <= {8'h00, data_wdata[31:8]};
                        end else begin
                            state    <= S_RD;
                            mem_re   <= 1'b1;
                            mem_addr <= data_addr;
                        end
                    end
                end
                S_RD: begin
                    if (beat_idx == last_beat) begin
                        mem_re <= 1'b0;
                        state  <= S_RDCAP;
                    end else begin
                        beat_idx <= beat_idx + 2'd1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                S_RDCAP: begin
                    state <= S_ACK;
                    if (own_fetch) begin
                        ifetch_ack  <= 1'b1;
                        ifetch_data <= word;
                    end else begin
                        data_ack   <= 1'b1;
                        data_rdata <= ext;
                    end
                end
                S_WR: begin
                    if (beat_idx == last_beat) begin
                        mem_we   <= 1'b0;
                        data_ack <= 1'b1;
                        state    <= S_ACK;
                    end else begin
                        beat_idx  <= beat_idx + 2'd1;
                        mem_addr  <= mem_addr + 1'b1;
                        mem_wdata <= wsh[7:0];
                        wsh       <= {8'h00, wsh[31:8]};
                    end
                end
                S_ERR:   state <= S_IDLE;
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_holo_mem_sequencer.sv
module tb_holo_mem_sequencer;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifetch_req = 1'b0;
    logic [31:0] ifetch_addr = 32'h0;
    logic        ifetch_ack;
    logic [31:0] ifetch_data;
    logic        ifetch_err;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [2:0]  data_f3 = 3'b000;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    holo_mem_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
        .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data), .ifetch_err(ifetch_err),
        .data_req(data_req), .data_we(data_we), .data_f3(data_f3),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .data_err(data_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mem [1024];
    logic [7:0]  ref_mem [1024];
    bit          re_q = 1'b0;
    logic [9:0]  ra_q = 10'h0;

    typedef struct {
        bit          f;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] d;
        bit          e;
        int          cyc;
        bit          cd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input bit f, input bit we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] d, input bit e, input int cyc, input bit cd);
        vec_t v;
        v.f = f; v.we = we; v.f3 = f3; v.a = a; v.wd = wd;
        v.d = d; v.e = e; v.cyc = cyc; v.cd = cd;
        return v;
    endfunction

    function automatic int nbeats(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    // One clock, then act as the synchronous byte memory: data for a read
    // issued last cycle appears now; a write in this cycle lands at once.
    task automatic step();
        @(posedge clk);
        #1;
        if (re_q) mem_rdata = mem[ra_q];
        re_q = mem_re;
        ra_q = mem_addr[9:0];
        if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
        if (mem_re || mem_we) begin
            vectors++;
            if (mem_re && mem_we) begin
                miscompares++;
                $display("FAIL strobe_overlap: re=%b we=%b, expected not both", mem_re, mem_we);
            end
        end
    endtask

    // Issue one request in the current (idle) cycle C0 and follow it to its ack.
    task automatic txn(input bit f, input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int exp_n,
                       output int cyc, output logic [31:0] rd, output logic er, output bit beats_ok);
        logic [31:0] ea;
        cyc = 0; rd = 32'h0; er = 1'b0; beats_ok = 1'b1;
        if (f) begin
            ifetch_req = 1'b1; ifetch_addr = a;
        end else begin
            data_req = 1'b1; data_we = we; data_f3 = f3; data_addr = a; data_wdata = wd;
        end
        for (int i = 1; i <= 12 && cyc == 0; i++) begin
            step();
            ea = a + 32'(i - 1);
            if (i <= exp_n) begin
                if (we) begin
                    if (!(mem_we && !mem_re && mem_addr == ea && mem_wdata == 8'(wd >> (8 * (i - 1)))))
                        beats_ok = 1'b0;
                end else if (!(mem_re && !mem_we && mem_addr == ea)) begin
                    beats_ok = 1'b0;
                end
            end else if (mem_re || mem_we) begin
                beats_ok = 1'b0;
            end
            if (f ? ifetch_ack : data_ack) begin
                cyc = i;
                rd  = f ? ifetch_data : data_rdata;
                er  = f ? ifetch_err : data_err;
            end
        end
        ifetch_req = 1'b0;
        data_req   = 1'b0;
        step();
    endtask

    task automatic tie(input int idx, input bit exp_fetch_first);
        int first = -1;
        int fcyc = 0;
        bit fdone = 1'b0;
        bit ddone = 1'b0;
        ifetch_req = 1'b1; ifetch_addr = 32'h4;
        data_req = 1'b1; data_we = 1'b0; data_f3 = 3'b010; data_addr = 32'h4;
        for (int i = 1; i <= 40 && !(fdone && ddone); i++) begin
            step();
            if (ifetch_ack && !fdone) begin
                fdone = 1'b1; ifetch_req = 1'b0;
                if (first < 0) begin first = 1; fcyc = i; end
            end
            if (data_ack && !ddone) begin
                ddone = 1'b1; data_req = 1'b0;
                if (first < 0) begin first = 0; fcyc = i; end
            end
        end
        ifetch_req = 1'b0;
        data_req = 1'b0;
        step();
        chk("tie_first_is_fetch", idx, first, {31'h0, exp_fetch_first});
        chk("tie_first_ack_cycle", idx, fcyc, 6);
        chk("tie_both_done", idx, {31'h0, fdone && ddone}, 1);
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic        er;
        bit          bok;
        int          n;
        bit          ack_seen;
        logic [31:0] last_load;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        mem[8] = 8'h80; mem[9] = 8'h5A; mem[10] = 8'h34; mem[11] = 8'h85;
        mem[18] = 8'h77; mem[19] = 8'h66; mem[1023] = 8'h12; mem[0] = 8'hF0;

        // Reset state
        #3;
        chk("reset_outputs_zero", 0,
            {31'h0, |{ifetch_ack, ifetch_data, ifetch_err, data_ack, data_rdata, data_err,
                      mem_addr, mem_re, mem_we, mem_wdata}}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Four consecutive ties alternate, fetch first after reset
        tie(0, 1'b1);
        tie(1, 1'b0);
        tie(2, 1'b1);
        tie(3, 1'b0);

        // Directed vectors
        tbl.push_back(mk(0, 0, 3'b010, 32'h4,  0, 32'h44332211, 0, 6, 1));
        tbl.push_back(mk(0, 0, 3'b000, 32'h8,  0, 32'hFFFFFF80, 0, 3, 1));
        tbl.push_back(mk(0, 0, 3'b100, 32'h8,  0, 32'h00000080, 0, 3, 1));
        tbl.push_back(mk(0, 0, 3'b001, 32'hA,  0, 32'hFFFF8534, 0, 4, 1));
        tbl.push_back(mk(0, 0, 3'b101, 32'hA,  0, 32'h00008534, 0, 4, 1));
        tbl.push_back(mk(0, 1, 3'b001, 32'h10, 32'hDEADBEEF, 32'h00008534, 0, 3, 1));
        tbl.push_back(mk(0, 0, 3'b010, 32'h10, 0, 32'h6677BEEF, 0, 6, 1));
        tbl.push_back(mk(0, 0, 3'b010, 32'h6,  0, TRAP ? 32'h0 : 32'h5A804433, TRAP, TRAP ? 1 : 6, !TRAP));
        tbl.push_back(mk(0, 0, 3'b011, 32'h0,  0, TRAP ? 32'h6677BEEF : 32'h5A804433, 1, 1, 1));
        tbl.push_back(mk(0, 1, 3'b011, 32'h0,  0, TRAP ? 32'h6677BEEF : 32'h5A804433, 1, 1, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h4,  0, 32'h44332211, 0, 6, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h5,  0, TRAP ? 32'h0 : 32'h80443322, TRAP, TRAP ? 1 : 6, !TRAP));
        tbl.push_back(mk(0, 0, 3'b001, 32'hFFFFFFFF, 0, TRAP ? 32'h0 : 32'hFFFFF012, TRAP, TRAP ? 1 : 4, !TRAP));
        tbl.push_back(mk(0, 1, 3'b000, 32'h20, 32'h000000A5, TRAP ? 32'h6677BEEF : 32'hFFFFF012, 0, 2, 1));
        tbl.push_back(mk(0, 0, 3'b000, 32'h20, 0, 32'hFFFFFFA5, 0, 3, 1));

        foreach (tbl[i]) begin
            n = tbl[i].f ? 4 : nbeats(tbl[i].f3);
            txn(tbl[i].f, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].e ? 0 : n, cyc, rd, er, bok);
            chk("tbl_ack_cycle", i, cyc, tbl[i].cyc);
            chk("tbl_err", i, {31'h0, er}, {31'h0, tbl[i].e});
            chk("tbl_beats", i, {31'h0, bok}, 1);
            if (tbl[i].cd) chk("tbl_data", i, rd, tbl[i].d);
        end

        // Reset pulsed in C2 of a word load
        data_req = 1'b1; data_we = 1'b0; data_f3 = 3'b010; data_addr = 32'h4;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_mem_re", 0, {31'h0, mem_re}, 0);
        chk("rst_mid_outputs_zero", 0,
            {31'h0, |{ifetch_ack, ifetch_data, ifetch_err, data_ack, data_rdata, data_err,
                      mem_addr, mem_re, mem_we, mem_wdata}}, 0);
        #1 rst = 1'b0;
        data_req = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_seen = ack_seen | data_ack | ifetch_ack;
        end
        chk("rst_no_ack", 0, {31'h0, ack_seen}, 0);
        txn(0, 0, 3'b010, 32'h4, 0, 4, cyc, rd, er, bok);
        chk("reissue_ack_cycle", 0, cyc, 6);
        chk("reissue_data", 0, rd, 32'h44332211);
        last_load = 32'h44332211;

        // Randomized transactions against a byte-array reference model
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int t = 0; t < 150; t++) begin
            bit          f, we, ill, err, sgn, mok;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_d;
            longint      v;
            int          exp_cyc;
            f  = ($urandom_range(0, 3) == 0);
            we = f ? 1'b0 : 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'($urandom_range(0, 127));
            wd = $urandom;
            if (f) begin
                n = 4; ill = 1'b0; sgn = 1'b0;
            end else begin
                ill = we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
                n   = nbeats(f3);
                sgn = !f3[2];
            end
            err = ill || (TRAP && (a % n != 0));
            exp_cyc = err ? 1 : (we ? n + 1 : n + 2);
            v = 0;
            for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[10'(a + 32'(k))]) << (8 * k));
            if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            exp_d = v[31:0];
            txn(f, we, f3, a, wd, err ? 0 : n, cyc, rd, er, bok);
            chk("rnd_ack_cycle", t, cyc, exp_cyc);
            chk("rnd_err", t, {31'h0, er}, {31'h0, err});
            chk("rnd_beats", t, {31'h0, bok}, 1);
            if (!f) begin
                if (!err && !we) last_load = exp_d;
                chk("rnd_rdata", t, rd, last_load);
            end else if (!err) begin
                chk("rnd_fetch", t, rd, exp_d);
            end
            if (we && !err) begin
                for (int k = 0; k < n; k++) ref_mem[10'(a + 32'(k))] = 8'(wd >> (8 * k));
                mok = 1'b1;
                for (int k = -1; k <= 4; k++)
                    if (mem[10'(a + 32'(k))] !== ref_mem[10'(a + 32'(k))]) mok = 1'b0;
                chk("rnd_store_mem", t, {31'h0, mok}, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
